// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared types for the ALU issue controller: the decoded ALU op encoding,
//   the ROB tag width and the queue entry struct moved between dispatch,
//   the issue queue and the FU.
//   Provides a default `DATA_WIDTH when the surrounding config has not set one.
//   Related build option: ALU_ISSUE_BYPASS_EN (used by alu_issue_ctrl).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package alu_issue_pkg;

  localparam int ALU_ISSUE_TAG_WIDTH = 6;

  // ALU_NOP is the all-zero encoding driven to an idle FU.
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SLT = 4'd8
  } decoded_alu_op_t;

  typedef struct packed {
    decoded_alu_op_t                op;
    logic [`DATA_WIDTH-1:0]         src1;
    logic [`DATA_WIDTH-1:0]         src2;
    logic [ALU_ISSUE_TAG_WIDTH-1:0] tag;
  } alu_issue_entry_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo
//   DEPTH-entry circular buffer of alu_issue_entry_t. The head entry is
//   presented combinationally; push writes at the write pointer, pop advances
//   the read pointer, flush empties the buffer in one cycle.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   flush        clear pointers and count next edge (wins over push/pop)
//   push         write wr_data at the tail
//   pop          retire the head entry
//   wr_data      entry to write
//   head         entry at the read pointer (undefined content when empty)
//   count        number of valid entries, 0..DEPTH
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  alu_issue_entry_t wr_data,
  output alu_issue_entry_t head,
  output logic [CW-1:0]    count
);

  alu_issue_entry_t mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue-side driver for the single-cycle ALU FU. Buffers decoded ops in an
//   alu_issue_fifo, issues one op per cycle to the FU, and presents the FU
//   result the cycle after issue to writeback with a valid/ready handshake.
//   Build option ALU_ISSUE_BYPASS_EN: with the queue empty, an accepted op
//   issues straight from the enqueue port in the same cycle.
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_flush                         drop queued and in-flight ops
//   i_enq_valid / o_enq_ready       dispatch handshake
//   i_enq_op/src1/src2/tag          op payload from dispatch
//   o_alu_enabled                   FU enable (FU latches operands this edge)
//   o_alu_op/src1/src2              FU operands, zero while not issuing
//   i_alu_dest                      FU result, valid the cycle after enable
//   o_wb_valid / i_wb_ready         writeback handshake
//   o_wb_data / o_wb_tag            result and its ROB tag
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = ALU_ISSUE_TAG_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_enq_valid,
  output logic                   o_enq_ready,
  input  decoded_alu_op_t        i_enq_op,
  input  logic [`DATA_WIDTH-1:0] i_enq_src1,
  input  logic [`DATA_WIDTH-1:0] i_enq_src2,
  input  logic [TAG_WIDTH-1:0]   i_enq_tag,
  output logic                   o_alu_enabled,
  output decoded_alu_op_t        o_alu_op,
  output logic [`DATA_WIDTH-1:0] o_alu_src1,
  output logic [`DATA_WIDTH-1:0] o_alu_src2,
  input  logic [`DATA_WIDTH-1:0] i_alu_dest,
  output logic                   o_wb_valid,
  input  logic                   i_wb_ready,
  output logic [`DATA_WIDTH-1:0] o_wb_data,
  output logic [TAG_WIDTH-1:0]   o_wb_tag
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    count;
  alu_issue_entry_t head;
  alu_issue_entry_t enq_entry;
  alu_issue_entry_t issue_entry;
  logic             enq_fire;
  logic             wb_free;
  logic             issue_q;
  logic             bypass;
  logic             issue;
  logic             push;
  logic             pop;
  logic             wb_pending;
  logic [TAG_WIDTH-1:0] wb_tag;

  // The struct tag field follows the package width; TAG_WIDTH must match it.
  assign enq_entry = '{op: i_enq_op, src1: i_enq_src1, src2: i_enq_src2, tag: i_enq_tag};

  // Ready is a pure function of state: no pass-through when full, and held
  // low during reset so every output reads zero while i_rst is asserted.
  assign o_enq_ready = ~i_rst & ~i_flush & (count < DEPTH_C);
  assign enq_fire    = i_enq_valid & o_enq_ready;

  // The result slot is free when empty or being drained this cycle.
  assign wb_free = ~wb_pending | i_wb_ready;
  assign issue_q = (count != '0) & wb_free & ~i_flush;

`ifdef ALU_ISSUE_BYPASS_EN
  // enq_fire already excludes flush and reset.
  assign bypass = enq_fire & (count == '0) & wb_free;
`else
  assign bypass = 1'b0;
`endif

  assign issue       = issue_q | bypass;
  assign push        = enq_fire & ~bypass;
  assign pop         = issue_q;
  assign issue_entry = bypass ? enq_entry : head;

  alu_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .flush   (i_flush),
    .push    (push),
    .pop     (pop),
    .wr_data (enq_entry),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_pending <= 1'b0;
      wb_tag     <= '0;
    end else if (i_flush) begin
      wb_pending <= 1'b0;
    end else if (issue) begin
      wb_pending <= 1'b1;
      wb_tag     <= issue_entry.tag;
    end else begin
      wb_pending <= wb_pending & ~i_wb_ready;
    end
  end

  // Idle FU sees all-zero operands so its inputs do not toggle.
  assign o_alu_enabled = issue;
  assign o_alu_op      = issue ? issue_entry.op   : ALU_NOP;
  assign o_alu_src1    = issue ? issue_entry.src1 : '0;
  assign o_alu_src2    = issue ? issue_entry.src2 : '0;

  assign o_wb_valid = wb_pending;
  assign o_wb_tag   = wb_tag;
  assign o_wb_data  = i_rst ? '0 : i_alu_dest;

endmodule
